// File: rtl/rtype_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for RV32I R-type ops.
// Owns the PC, drives the imem handshake and the register-file/ALU strobes.
module rtype_sequencer #(
   parameter int                  PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                  CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          instr,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic [3:0]           alu_op,
   output logic                 rf_rd_en,
   output logic                 alu_en,
   output logic                 rf_wr_en,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [CNT_WIDTH-1:0] retired,
   output logic                 busy,
   output logic                 illegal,
   output logic                 halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_BAD = 4'hF;

   state_t     state;
   logic [3:0] fetch_op;
   logic [3:0] instr_op;

   // Maps an instruction word to its ALU code; OP_BAD marks anything illegal.
   function automatic logic [3:0] op_f(input logic [31:0] w);
      logic [3:0] op;
      op = OP_BAD;
      if (w[6:0] == 7'b0110011) begin
         case ({w[31:25], w[14:12]})
            10'b0000000_000: op = 4'd0;
            10'b0100000_000: op = 4'd1;
            10'b0000000_001: op = 4'd2;
            10'b0000000_010: op = 4'd3;
            10'b0000000_011: op = 4'd4;
            10'b0000000_100: op = 4'd5;
            10'b0000000_101: op = 4'd6;
            10'b0100000_101: op = 4'd7;
            10'b0000000_110: op = 4'd8;
            10'b0000000_111: op = 4'd9;
            default:         op = OP_BAD;
         endcase
      end
      return op;
   endfunction

   assign fetch_op  = op_f(imem_rdata);
   assign instr_op  = op_f(instr);
   assign imem_addr = pc;
   assign rs1       = instr[19:15];
   assign rs2       = instr[24:20];
   assign rd        = instr[11:7];

   // Outputs are set on the edge entering each state, so they track it exactly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         instr    <= '0;
         alu_op   <= '0;
         retired  <= '0;
         illegal  <= 1'b0;
         imem_req <= 1'b0;
         rf_rd_en <= 1'b0;
         alu_en   <= 1'b0;
         rf_wr_en <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  instr    <= imem_rdata;
                  state    <= S_DECODE;
                  imem_req <= 1'b0;
                  rf_rd_en <= (fetch_op != OP_BAD);
               end
            end
            S_DECODE: begin
               rf_rd_en <= 1'b0;
               if (instr_op != OP_BAD) begin
                  alu_op <= instr_op;
                  alu_en <= 1'b1;
                  state  <= S_EXEC;
               end else begin
                  illegal <= 1'b1;
                  halted  <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_HALT;
               end
            end
            S_EXEC: begin
               alu_en   <= 1'b0;
               rf_wr_en <= (rd != 5'd0);
               state    <= S_WB;
            end
            S_WB: begin
               rf_wr_en <= 1'b0;
               pc       <= pc + PC_WIDTH'(4);
               retired  <= retired + CNT_WIDTH'(1);
               if (stop) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer: vector table run through a scoreboard,
// plus hand sequences for reset, x0, illegal halt and PC wrap.
module tb_rtype_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [4:0]  rs1, rs2, rd;
   logic [3:0]  alu_op;
   logic        rf_rd_en, alu_en, rf_wr_en;
   logic [31:0] pc;
   logic [15:0] retired;
   logic        busy, illegal, halted;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_instr;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [3:0]  w_op;
   logic        w_rd_en, w_alu_en, w_wr_en;
   logic [31:0] w_pc;
   logic [15:0] w_ret;
   logic        w_busy, w_ill, w_halt;

   rtype_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd),
      .alu_op(alu_op), .rf_rd_en(rf_rd_en), .alu_en(alu_en),
      .rf_wr_en(rf_wr_en), .pc(pc), .retired(retired),
      .busy(busy), .illegal(illegal), .halted(halted)
   );

   rtype_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(w_instr), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd),
      .alu_op(w_op), .rf_rd_en(w_rd_en), .alu_en(w_alu_en),
      .rf_wr_en(w_wr_en), .pc(w_pc), .retired(w_ret),
      .busy(w_busy), .illegal(w_ill), .halted(w_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          dly;
      logic        legal;
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } vec_t;

   typedef struct {
      logic [3:0] op;
      logic [4:0] rd;
   } exp_t;

   vec_t        vecs[12];
   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;
   logic [15:0] exp_ret;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7,
                                      input logic [2:0] f3,
                                      input logic [4:0] a,
                                      input logic [4:0] b,
                                      input logic [4:0] d);
      return {f7, b, a, f3, d, 7'b0110011};
   endfunction

   function automatic vec_t v(input logic [31:0] w, input int dly,
                              input logic lg, input logic [3:0] op);
      vec_t r;
      r.word  = w;
      r.dly   = dly;
      r.legal = lg;
      r.op    = op;
      r.rs1   = w[19:15];
      r.rs2   = w[24:20];
      r.rd    = w[11:7];
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_pc  = 32'h0;
      exp_ret = 16'h0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_fetch", busy, 1);
   endtask

   // Entered at a negedge with the DUT in FETCH.
   task automatic exec_one(input vec_t t, input logic stp);
      int   n;
      exp_t e;
      n = 0;
      while (imem_req && n < 20) begin
         n++;
         imem_ack   = (n == t.dly + 1);
         imem_rdata = imem_ack ? t.word : 32'hDEAD_BEEF;
         if (imem_ack && t.legal) sb.push_back('{t.op, t.rd});
         @(negedge clk);
      end
      imem_ack = 1'b0;
      chk("req_cycles", n, t.dly + 1);
      chk("instr", instr, t.word);
      chk("rs", {rs1, rs2, rd}, {t.rs1, t.rs2, t.rd});
      chk("rd_en", rf_rd_en, t.legal);
      chk("alu_en_dec", alu_en, 0);
      if (!t.legal) begin
         @(negedge clk);
         chk("halt", {halted, illegal, busy}, 3'b110);
         chk("halt_strobes", {imem_req, rf_rd_en, alu_en, rf_wr_en}, 0);
         chk("halt_pc", pc, exp_pc);
         start = 1'b1;
         repeat (3) @(negedge clk);
         start = 1'b0;
         chk("halt_sticky", {halted, imem_req, busy}, 3'b100);
         return;
      end
      @(negedge clk);
      chk("alu_en", {alu_en, rf_rd_en}, 2'b10);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("alu_op", alu_op, e.op);
         chk("sb_rd", rd, e.rd);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0013;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("wr_en", {rf_wr_en, alu_en}, {(t.rd != 5'd0), 1'b0});
      chk("instr_hold", instr, t.word);
      stop = stp;
      @(negedge clk);
      stop = 1'b0;
      exp_pc  = exp_pc + 32'd4;
      exp_ret = exp_ret + 16'd1;
      chk("pc", pc, exp_pc);
      chk("retired", retired, exp_ret);
      chk("next_state", {imem_req, busy}, stp ? 2'b00 : 2'b11);
   endtask

   initial begin
      vecs[0]  = v(32'h002081B3, 0, 1'b1, 4'd0);
      vecs[1]  = v(32'h407302B3, 3, 1'b1, 4'd1);
      vecs[2]  = v(32'h00208033, 0, 1'b1, 4'd0);
      vecs[3]  = v(mk(7'h00, 3'd1, 5'd4, 5'd9, 5'd31), 1, 1'b1, 4'd2);
      vecs[4]  = v(mk(7'h00, 3'd2, 5'd10, 5'd11, 5'd12), 0, 1'b1, 4'd3);
      vecs[5]  = v(mk(7'h00, 3'd3, 5'd13, 5'd14, 5'd15), 2, 1'b1, 4'd4);
      vecs[6]  = v(mk(7'h00, 3'd4, 5'd16, 5'd17, 5'd18), 0, 1'b1, 4'd5);
      vecs[7]  = v(mk(7'h00, 3'd5, 5'd19, 5'd20, 5'd21), 0, 1'b1, 4'd6);
      vecs[8]  = v(mk(7'h20, 3'd5, 5'd22, 5'd23, 5'd24), 1, 1'b1, 4'd7);
      vecs[9]  = v(mk(7'h00, 3'd6, 5'd25, 5'd26, 5'd27), 0, 1'b1, 4'd8);
      vecs[10] = v(mk(7'h00, 3'd7, 5'd28, 5'd29, 5'd30), 0, 1'b1, 4'd9);
      vecs[11] = v(32'h00208033, 0, 1'b1, 4'd0);

      imem_rdata = 32'h0;
      do_reset();
      chk("rst_pc", pc, 32'h0);
      chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
      chk("rst_ret", retired, 0);
      chk("rst_regs", {instr, alu_op}, 0);
      chk("rst_out", {imem_req, rf_rd_en, alu_en, rf_wr_en,
                      busy, illegal, halted}, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle", {busy, imem_req}, 0);
      end

      kick();
      for (int i = 0; i < 12; i++) begin
         exec_one(vecs[i], i == 11);
         if (i == 0) chk("pc_wrap", w_pc, 32'h0);
      end

      kick();
      imem_ack   = 1'b1;
      imem_rdata = 32'h002081B3;
      reset      = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      reset    = 1'b1;
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_out", {imem_req, busy, rf_rd_en, retired}, 0);
      exp_pc  = 32'h0;
      exp_ret = 16'h0;
      @(negedge clk);
      chk("midrst_idle", {imem_req, busy}, 0);

      kick();
      exec_one(vecs[0], 1'b0);
      exec_one(v(32'h00100093, 0, 1'b0, 4'd0), 1'b0);
      do_reset();
      chk("clr_ill", {illegal, halted, pc}, 0);

      kick();
      exec_one(vecs[1], 1'b0);
      exec_one(v(32'h022081B3, 1, 1'b0, 4'd0), 1'b0);
      do_reset();
      chk("clr_ill2", {illegal, halted, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rtype_sequencer.md
# rtype_sequencer

Multi-cycle control FSM for the R-type integer datapath. It fetches each instruction over a request/acknowledge instruction-memory port and latches it. It then splits the instruction into register specifiers and an ALU operation code, and sequences the register-file read, ALU execute and register-file write strobes. It sits between instruction memory and the register file/ALU, owns the program counter, and halts on the first instruction that is not a legal RV32I R-type.

## Interface
- PC_WIDTH, 32, program counter and instruction address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, retired-instruction counter width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- start  in  1  begin sequencing; honoured only in IDLE
- stop  in  1  return to IDLE after the current instruction; sampled only in WB
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_WIDTH  fetch address, equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  latched instruction register
- rs1, rs2, rd  out  5 each  register specifiers decoded from instr
- alu_op  out  4  ALU operation code, valid from EXEC through WB
- rf_rd_en  out  1  register-file read strobe
- alu_en  out  1  ALU execute strobe
- rf_wr_en  out  1  register-file write strobe
- pc  out  PC_WIDTH  current program counter
- retired  out  CNT_WIDTH  count of written-back instructions
- busy  out  1  high in FETCH, DECODE, EXEC and WB
- illegal  out  1  sticky; set on an illegal instruction
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: all strobes are low. If start=1, go to FETCH.
- FETCH: imem_req=1 and imem_addr=pc. Wait while imem_ack=0. When imem_ack=1, load instr<=imem_rdata and go to DECODE.
- DECODE: legal requires instr[6:0]=7'b0110011 and one of the funct7/funct3 pairs below.
  - 0000000/000 → ADD=0; 0100000/000 → SUB=1; 0000000/001 → SLL=2; 0000000/010 → SLT=3; 0000000/011 → SLTU=4.
  - 0000000/100 → XOR=5; 0000000/101 → SRL=6; 0100000/101 → SRA=7; 0000000/110 → OR=8; 0000000/111 → AND=9.
  - If legal: rf_rd_en=1, latch alu_op, go to EXEC.
  - If not legal: set illegal<=1, leave pc unchanged, go to HALT. rf_rd_en stays 0.
- rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]. These are continuous slices of the registered instr.
- EXEC: alu_en=1, go to WB.
- WB:
  - rf_wr_en=1 only if rd≠0. Writes to x0 are suppressed, but the instruction still retires.
  - Update pc<=pc+4 (wraps modulo 2^PC_WIDTH) and retired<=retired+1 (wraps).
  - Go to IDLE if stop=1, otherwise to FETCH.
- HALT: all strobes low. Exit only through reset.
- start outside IDLE and stop outside WB are ignored.
- Reset (reset=0 at an edge), from any state including mid-fetch:
  - state=IDLE, pc=RESET_PC, instr=0, alu_op=0, retired=0, illegal=0.
  - Outputs: imem_req=0, rf_rd_en=0, alu_en=0, rf_wr_en=0, busy=0, halted=0.
  - An imem_ack arriving in the same cycle is discarded.

## Timing
- Strobes and imem_req are Moore outputs decoded from the state register. They assert in the cycle the FSM is in the corresponding state.
- start=1 at edge N puts the FSM in FETCH for cycle N+1.
- Fetch latency: with imem_ack=1 in the first FETCH cycle, each instruction takes exactly 4 cycles: FETCH, DECODE, EXEC, WB. Every cycle of ack delay adds one cycle.
- imem_req stays high through the ack cycle and drops the cycle after. imem_ack outside FETCH is ignored.
- instr, rs1/rs2/rd are valid from DECODE onward. alu_op is valid from EXEC onward. pc and retired update at the end of WB and are visible in the next FETCH.
- Back-to-back instructions have no gap: WB is followed directly by FETCH.

## Test plan
- Reset, then idle: after reset=0→1 → pc=0, retired=0, busy=0, all strobes 0. With start=0 held for 10 cycles, the FSM stays in IDLE.
- ADD x3,x1,x2 (0x002081B3), with ack in the first FETCH cycle:
  - rs1=1, rs2=2, rd=3.
  - rf_rd_en in cycle 2, alu_en in cycle 3 with alu_op=0, rf_wr_en in cycle 4.
  - Then pc=4, retired=1, and FETCH again.
- SUB x5,x6,x7 (0x407302B3) with imem_ack delayed 3 cycles:
  - imem_req is high for 4 cycles.
  - alu_op=1, rd=5, 7 cycles total from FETCH entry to WB exit.
- ADD x0,x1,x2 (0x00208033) → rf_wr_en stays 0 in WB, retired still increments, pc+=4.
- Illegal instructions, each after one legal instruction:
  - ADDI 0x00100093 → illegal=1, halted=1, pc=4, no strobes. start is ignored afterwards.
  - MUL 0x022081B3 → same response.
  - Reset then clears illegal and halted.
- stop and reset:
  - stop=1 during WB → IDLE next cycle, busy=0.
  - reset=0 asserted mid-FETCH with imem_ack=1 in the same cycle → instr=0, IDLE, pc=RESET_PC.
  - pc preset near 2^32-4 via RESET_PC=32'hFFFF_FFFC → pc wraps to 0 after one instruction.
